laser_spot_tracker: RTL
=======================

# laser_spot_tracker

Parametrised successor to the single-run red laser detector in the image-processing IP. It scores each streamed pixel as selected-channel minus the sum of the other two, and finds horizontal runs of pixels above threshold. It reports one spot per frame: either the first qualifying run or the longest one, with a registered per-frame result and a found flag. It sits beside the pixel-stream path, sharing its x/y counters and frame markers.

## Interface
Parameters:
- COORD_W, 16: width of x, y, run length and coordinate outputs.
- PIXEL_W, 24: pixel width; channels are G=[7:0], B=[15:8], R=[23:16] (scaled as PIXEL_W/3 per channel).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  pixel valid; all state advances only when en=1.
- sof  in  1  first pixel of frame (qualified by en).
- eol  in  1  last pixel of line (qualified by en).
- eof  in  1  last pixel of frame (qualified by en; implies eol).
- data  in  PIXEL_W  pixel.
- x, y  in  COORD_W  coordinates of the current pixel.
- threshold  in  8  score threshold.
- chan_sel  in  2  0=R, 1=G, 2=B, 3=R (alias).
- mode  in  1  0=first qualifying run, 1=longest run; sampled at sof.
- min_run  in  COORD_W  minimum qualifying run length (0 and 1 both mean 1).
- spot_xy  out  2*COORD_W  {x_center, y} of reported spot.
- spot_len  out  COORD_W  reported run length.
- spot_found  out  1  frame had a qualifying run.
- result_valid  out  1  one-cycle pulse when the outputs update.
- busy  out  1  inside a frame (SCAN or LOCKED).
- debug  out  PIXEL_W  zero-extended current score.

## Operation
- Score: the selected channel is S; the other two are A and B. Sum=A+B (9 bits). d = S>Sum ? S-Sum : 0. hit = d > threshold (strict).
- States: IDLE (wait for sof), SCAN, LOCKED (mode 0 only, after the first qualifying run closes). Transitions:
  - Any state to SCAN on en&sof.
  - SCAN to LOCKED when a qualifying run closes and frame mode=0.
  - SCAN or LOCKED to IDLE on en&eof.
- A sof pixel is itself scanned. sof while busy discards the partial frame with no result.
- Run tracking in SCAN:
  - On a hit with run_len=0: latch x_start=x, run_y=y, run_len=1.
  - On a further hit: run_len+1, saturating at all-ones.
  - A run closes on a non-hit pixel (length excludes it) or on an eol/eof pixel (length includes it if it is a hit). A run never spans lines.
- Qualification: run_len ≥ max(min_run,1).
  - Center = x_start + ((run_len-1)>>1), COORD_W wrap.
- Candidate update:
  - mode 0: the first qualifying run is stored, then LOCKED. No further updates.
  - mode 1: the candidate is replaced when the new length is strictly greater; ties keep the earlier run.
- LOCKED ignores hits until eof.
- Frame end (en&eof): after closing any open run, copy the candidate to spot_xy and spot_len, set spot_found=1, and pulse result_valid.
  - With no candidate: spot_found=0, result_valid pulses, and spot_xy/spot_len hold the previous frame's values.
- en=0 freezes all state; frame markers without en are ignored.

## Timing
- Reset values: spot_xy=0, spot_len=0, spot_found=0, result_valid=0, busy=0, state=IDLE, run and candidate registers cleared.
- debug is combinational from data/threshold/chan_sel.
- Run closure and candidate update are registered on the closing pixel's edge.
- result_valid is high exactly the cycle after the en&eof edge. spot_* and spot_found change on that same edge and hold until the next frame end.
- busy rises the cycle after sof and falls the cycle after eof.
- Reset mid-frame aborts with no result_valid; the next frame requires sof.
- An eof pixel arriving in IDLE (no sof) is ignored.

## Test plan
- chan_sel=0, threshold=20, min_run=5, mode=0; line y=3 has hits at x=10..16 (R=200,G=B=0); eof → spot_xy={13,3}, spot_len=7, spot_found=1, result_valid one cycle.
- mode=1, runs x=2..5 (len 4, y=1), x=40..49 (len 10, y=2), x=60..69 (len 10, y=4), min_run=3 → {44,2}, len 10 (tie keeps earlier).
- Run x=630..639 closed by eol at x=639, next line starts with hit at x=0 → two separate runs; len 10 centered at 634; no cross-line merge.
- Pixel R=100, G=40, B=40 with threshold=20 → d=20, no hit; R=100, G=40, B=39 → d=21, hit. chan_sel=2 with B=255, R=G=0 → hit.
- Frame with no qualifying runs after a good frame → spot_found=0, result_valid pulses, spot_xy unchanged.
- en toggled 50% throughout the first test → identical result. reset_n low mid-frame → outputs 0, no result_valid. sof mid-frame → partial frame discarded.

Source files
------------

// File: rtl/laser_spot_tracker.sv
// Per-frame laser spot finder: scores each pixel as the selected channel minus the other two.
// Reports either the first qualifying horizontal run or the longest one at every frame end.
module laser_spot_tracker #(
  parameter int COORD_W = 16,
  parameter int PIXEL_W = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   sof,
  input  logic                   eol,
  input  logic                   eof,
  input  logic [PIXEL_W-1:0]     data,
  input  logic [COORD_W-1:0]     x,
  input  logic [COORD_W-1:0]     y,
  input  logic [7:0]             threshold,
  input  logic [1:0]             chan_sel,
  input  logic                   mode,
  input  logic [COORD_W-1:0]     min_run,
  output logic [2*COORD_W-1:0]   spot_xy,
  output logic [COORD_W-1:0]     spot_len,
  output logic                   spot_found,
  output logic                   result_valid,
  output logic                   busy,
  output logic [PIXEL_W-1:0]     debug
);
  localparam int CW = PIXEL_W / 3;
  localparam int DW = (CW + 1 > 9) ? CW + 1 : 9;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LOCKED} state_t;

  state_t               r_state;
  logic                 r_frame_mode;
  logic [COORD_W-1:0]   r_run_len, r_run_xs, r_run_y;
  logic                 r_cand_valid;
  logic [COORD_W-1:0]   r_cand_len, r_cand_x, r_cand_y;
  logic [2*COORD_W-1:0] r_spot_xy;
  logic [COORD_W-1:0]   r_spot_len;
  logic                 r_spot_found, r_result_valid;

  logic [CW-1:0] w_ch_r, w_ch_g, w_ch_b, w_sel, w_oth_a, w_oth_b;
  logic [CW:0]   w_sum, w_diff;
  logic          w_hit;

  assign w_ch_g = data[CW-1:0];
  assign w_ch_b = data[2*CW-1:CW];
  assign w_ch_r = data[3*CW-1:2*CW];

  always_comb begin
    w_sel   = w_ch_r;
    w_oth_a = w_ch_g;
    w_oth_b = w_ch_b;
    case (chan_sel)
      2'd1:    begin w_sel = w_ch_g; w_oth_a = w_ch_r; w_oth_b = w_ch_b; end
      2'd2:    begin w_sel = w_ch_b; w_oth_a = w_ch_r; w_oth_b = w_ch_g; end
      default: begin w_sel = w_ch_r; w_oth_a = w_ch_g; w_oth_b = w_ch_b; end
    endcase
  end

  assign w_sum  = {1'b0, w_oth_a} + {1'b0, w_oth_b};
  assign w_diff = ({1'b0, w_sel} > w_sum) ? ({1'b0, w_sel} - w_sum) : '0;
  assign w_hit  = DW'(w_diff) > DW'(threshold);
  assign debug  = PIXEL_W'(w_diff);

  // A sof pixel starts a fresh frame, so it sees cleared run/candidate state.
  logic               w_active, w_in_frame, w_mode, w_close, w_qual, w_take;
  logic [COORD_W-1:0] w_len_cur, w_xs_cur, w_y_cur;
  logic [COORD_W-1:0] w_len_upd, w_xs_upd, w_y_upd, w_min, w_center;
  logic               w_cv_cur, w_cv_next;
  logic [COORD_W-1:0] w_cl_cur, w_cx_cur, w_cy_cur, w_cl_next, w_cx_next, w_cy_next;

  assign w_active   = sof || (r_state == S_SCAN);
  assign w_in_frame = sof || (r_state != S_IDLE);
  assign w_mode     = sof ? mode : r_frame_mode;
  assign w_len_cur  = sof ? '0 : r_run_len;
  assign w_xs_cur   = sof ? '0 : r_run_xs;
  assign w_y_cur    = sof ? '0 : r_run_y;
  assign w_cv_cur   = sof ? 1'b0 : r_cand_valid;
  assign w_cl_cur   = sof ? '0 : r_cand_len;
  assign w_cx_cur   = sof ? '0 : r_cand_x;
  assign w_cy_cur   = sof ? '0 : r_cand_y;

  always_comb begin
    w_len_upd = w_len_cur;
    w_xs_upd  = w_xs_cur;
    w_y_upd   = w_y_cur;
    if (w_hit) begin
      if (w_len_cur == '0) begin
        w_len_upd = COORD_W'(1);
        w_xs_upd  = x;
        w_y_upd   = y;
      end else if (w_len_cur != '1) begin
        w_len_upd = w_len_cur + COORD_W'(1);
      end
    end
  end

  // A miss closes the run without itself; a line end closes it including itself.
  assign w_close  = !w_hit || eol || eof;
  assign w_min    = (min_run == '0) ? COORD_W'(1) : min_run;
  assign w_qual   = w_active && w_close && (w_len_upd >= w_min);
  assign w_center = w_xs_upd + ((w_len_upd - COORD_W'(1)) >> 1);
  assign w_take   = w_qual && (!w_mode || !w_cv_cur || (w_len_upd > w_cl_cur));

  assign w_cv_next = w_take ? 1'b1      : w_cv_cur;
  assign w_cl_next = w_take ? w_len_upd : w_cl_cur;
  assign w_cx_next = w_take ? w_center  : w_cx_cur;
  assign w_cy_next = w_take ? w_y_upd   : w_cy_cur;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_frame_mode   <= 1'b0;
      r_run_len      <= '0;
      r_run_xs       <= '0;
      r_run_y        <= '0;
      r_cand_valid   <= 1'b0;
      r_cand_len     <= '0;
      r_cand_x       <= '0;
      r_cand_y       <= '0;
      r_spot_xy      <= '0;
      r_spot_len     <= '0;
      r_spot_found   <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (en && w_in_frame) begin
        r_frame_mode <= w_mode;
        r_cand_valid <= w_cv_next;
        r_cand_len   <= w_cl_next;
        r_cand_x     <= w_cx_next;
        r_cand_y     <= w_cy_next;
        if (w_active) begin
          r_run_len <= w_close ? '0 : w_len_upd;
          r_run_xs  <= w_xs_upd;
          r_run_y   <= w_y_upd;
        end
        if (eof) begin
          r_state        <= S_IDLE;
          r_result_valid <= 1'b1;
          r_spot_found   <= w_cv_next;
          if (w_cv_next) begin
            r_spot_xy  <= {w_cx_next, w_cy_next};
            r_spot_len <= w_cl_next;
          end
        end else if (w_take && !w_mode) begin
          r_state <= S_LOCKED;
        end else if (sof) begin
          r_state <= S_SCAN;
        end
      end
    end
  end

  assign spot_xy      = r_spot_xy;
  assign spot_len     = r_spot_len;
  assign spot_found   = r_spot_found;
  assign result_valid = r_result_valid;
  assign busy         = (r_state != S_IDLE);
endmodule
